fir_sequencer: RTL and testbench
================================

Name: fir_sequencer

Overview:
- Moore FSM that sequences the shared register-file datapath (op/src1/src2/dest command bus) to run one 4-tap FIR evaluation per accepted sample.
- Also loads the 4 filter coefficients, drives the sample-counter strobes (cnt_up, clear), and reports busy (modwait) and arithmetic overflow (err).
- Sits between the external handshake pins and the datapath, inside the top-level filter.

Parameters:
- NTAPS, 4, number of taps; fixed register map below assumes 4.
- OP_W, 3, opcode width.
- REG_W, 4, register-index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_ready  in  1  sample valid; must stay high until the LOAD cycle.
- load_coeff  in  1  coefficient valid; one coefficient accepted per IDLE visit.
- overflow  in  1  datapath overflow flag, combinational for the op issued this cycle.
- op  out  OP_W  datapath opcode: NOP=0, COPY=1, LOAD1=2, LOAD2=3, ADD=4, SUB=5, MUL=6.
- src1  out  REG_W  source register A.
- src2  out  REG_W  source register B.
- dest  out  REG_W  destination register.
- cnt_up  out  1  one-cycle pulse per accepted sample.
- clear  out  1  one-cycle pulse when coefficient F0 is loaded.
- modwait  out  1  registered busy flag.
- err  out  1  sticky error flag, cleared on the next accepted request.

Behaviour:
- Register map:
  - R0 = output register.
  - R1..R4 = samples, R1 newest.
  - R5..R8 = coefficients F0..F3.
  - R9 = accumulator; R10 = product temp.
- Reset (rst high at a clk edge):
  - state IDLE; op=NOP; src1/src2/dest=0; cnt_up=0; clear=0; modwait=0; err=0; coeff_idx=0.
  - Reset overrides any in-flight sequence in the same cycle.
- IDLE: op=NOP.
  - load_coeff has priority over data_ready when both are high.
  - load_coeff high -> COEF.
  - else data_ready high -> SH3.
- COEF (1 cycle): op=LOAD2, dest=5+coeff_idx; clear=1 iff coeff_idx==0.
  - coeff_idx increments, wrapping 3->0.
  - Next state WAITC.
- WAITC: op=NOP; stays until load_coeff is low, then IDLE. One coefficient per load_coeff pulse.
- Sample sequence, 11 command cycles:
  - SH3: COPY R4<-R3
  - SH2: COPY R3<-R2
  - SH1: COPY R2<-R1
  - LOAD: LOAD1 R1<-sample, cnt_up=1
  - M1: MUL R9=R1*R5
  - M2: MUL R10=R2*R6
  - A2: ADD R9=R9+R10
  - M3: MUL R10=R3*R7
  - A3: ADD R9=R9+R10
  - M4: MUL R10=R4*R8
  - A4: ADD R0=R9+R10
  - A4 -> IDLE.
- Unused src fields are driven 0.
- LOAD with data_ready low: issue NOP, no cnt_up, go to ERR.
- A2/A3/A4 with overflow=1: go to ERR next cycle; R0 is not guaranteed valid.
- ERR: op=NOP; err=1, modwait=0. load_coeff or data_ready leaves ERR exactly as from IDLE, and err clears at that transition.
- modwait is registered:
  - It is 1 in every cycle the FSM is in COEF, SH3..A4 or WAITC.
  - It is 0 in IDLE and ERR.
  - It rises on the edge that leaves IDLE/ERR and falls on the edge that enters IDLE/ERR.
- Latency: data_ready sampled at edge N; R0 is written by the A4 command at edge N+11; modwait falls at edge N+11.
- data_ready held high after IDLE is reached starts a new sample. The source must deassert it; no edge detection is performed.

Optional Feature:
- Macro: FIR_SEQ_ALT_SIGN_EN.
- Defined: A2 and A4 issue SUB instead of ADD, giving the signed tap pattern +F0 -F1 +F2 -F3. Overflow handling is unchanged.
- Undefined: all accumulate steps use ADD, as above.

Decomposition:
- Package fir_seq_pkg holds:
  - op_t enum (NOP..MUL, OP_W bits);
  - state_t enum (IDLE, COEF, WAITC, SH3, SH2, SH1, LOAD, M1, M2, A2, M3, A3, M4, A4, ERR);
  - localparams R_OUT=0, R_S1=1, R_F0=5, R_ACC=9, R_TMP=10.
- Single module: next-state/output decode plus a state register. No sub-module needed.

Test Plan:
- Reset: hold rst 2 cycles mid-sequence (state M2) -> next cycle op=NOP, modwait=0, err=0, state IDLE, coeff_idx=0.
- Coefficient load: 4 load_coeff pulses -> LOAD2 with dest 5,6,7,8 in turn; clear=1 only on dest=5; 5th pulse -> dest=5 again.
- Sample sequence: data_ready at edge N -> op sequence 1,1,1,2,6,6,4,6,4,6,4 with dests 4,3,2,1,9,10,9,10,9,10,0; cnt_up high only in the LOAD cycle; modwait high N+1..N+11.
- Dropped sample: data_ready high for one cycle only -> LOAD cycle issues NOP, err=1, modwait=0, cnt_up stays 0.
- Overflow: force overflow=1 during A3 -> ERR, err=1; a subsequent data_ready clears err and restarts at SH3.
- Priority: load_coeff and data_ready both high in IDLE -> COEF first; the sample starts after WAITC returns to IDLE with data_ready still high.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared opcode/state encodings and register map for the FIR sequencer.
// Used by fir_sequencer; see that file for the FIR_SEQ_ALT_SIGN_EN option.
package fir_seq_pkg;

    localparam int NTAPS_DEF = 4;
    localparam int OP_W_DEF  = 3;
    localparam int REG_W_DEF = 4;

    typedef enum logic [OP_W_DEF-1:0] {
        NOP   = 3'd0,
        COPY  = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        ADD   = 3'd4,
        SUB   = 3'd5,
        MUL   = 3'd6
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        COEF,
        WAITC,
        SH3,
        SH2,
        SH1,
        LOAD,
        M1,
        M2,
        A2,
        M3,
        A3,
        M4,
        A4,
        ERR
    } state_t;

    // Register file map: R1..R4 hold samples (R1 newest), R5..R8 hold F0..F3.
    localparam int R_OUT = 0;
    localparam int R_S1  = 1;
    localparam int R_F0  = 5;
    localparam int R_ACC = 9;
    localparam int R_TMP = 10;

endpackage

// File: rtl/fir_sequencer.sv
// Moore FSM issuing datapath commands for coefficient loads and 4-tap FIR runs.
// Define FIR_SEQ_ALT_SIGN_EN to subtract the odd taps (+F0 -F1 +F2 -F3).
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic             load_coeff,
    input  logic             overflow,
    output logic [OP_W-1:0]  op,
    output logic [REG_W-1:0] src1,
    output logic [REG_W-1:0] src2,
    output logic [REG_W-1:0] dest,
    output logic             cnt_up,
    output logic             clear,
    output logic             modwait,
    output logic             err
);

    localparam int IDX_W = $clog2(NTAPS);

`ifdef FIR_SEQ_ALT_SIGN_EN
    localparam op_t ODD_TAP_ACC = SUB;
`else
    localparam op_t ODD_TAP_ACC = ADD;
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] coeff_idx_q, coeff_idx_d;
    logic             modwait_q, modwait_d;
    logic             err_q, err_d;

    op_t              op_c;
    logic [REG_W-1:0] src1_c, src2_c, dest_c;
    logic             cnt_up_c, clear_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            coeff_idx_q <= '0;
            modwait_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            coeff_idx_q <= coeff_idx_d;
            modwait_q   <= modwait_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        coeff_idx_d = coeff_idx_q;
        op_c        = NOP;
        src1_c      = '0;
        src2_c      = '0;
        dest_c      = '0;
        cnt_up_c    = 1'b0;
        clear_c     = 1'b0;

        case (state_q)
            // ERR accepts new requests exactly like IDLE; coefficients win ties.
            IDLE, ERR: begin
                if (load_coeff) begin
                    state_d = COEF;
                end else if (data_ready) begin
                    state_d = SH3;
                end
            end
            COEF: begin
                op_c    = LOAD2;
                dest_c  = REG_W'(R_F0) + REG_W'(coeff_idx_q);
                clear_c = (coeff_idx_q == '0);
                if (coeff_idx_q == IDX_W'(NTAPS - 1)) begin
                    coeff_idx_d = '0;
                end else begin
                    coeff_idx_d = coeff_idx_q + 1'b1;
                end
                state_d = WAITC;
            end
            WAITC: begin
                if (!load_coeff) begin
                    state_d = IDLE;
                end
            end
            SH3: begin
                op_c    = COPY;
                src1_c  = REG_W'(R_S1 + 2);
                dest_c  = REG_W'(R_S1 + 3);
                state_d = SH2;
            end
            SH2: begin
                op_c    = COPY;
                src1_c  = REG_W'(R_S1 + 1);
                dest_c  = REG_W'(R_S1 + 2);
                state_d = SH1;
            end
            SH1: begin
                op_c    = COPY;
                src1_c  = REG_W'(R_S1);
                dest_c  = REG_W'(R_S1 + 1);
                state_d = LOAD;
            end
            // A sample withdrawn before this cycle is treated as lost.
            LOAD: begin
                if (data_ready) begin
                    op_c     = LOAD1;
                    dest_c   = REG_W'(R_S1);
                    cnt_up_c = 1'b1;
                    state_d  = M1;
                end else begin
                    state_d  = ERR;
                end
            end
            M1: begin
                op_c    = MUL;
                src1_c  = REG_W'(R_S1);
                src2_c  = REG_W'(R_F0);
                dest_c  = REG_W'(R_ACC);
                state_d = M2;
            end
            M2: begin
                op_c    = MUL;
                src1_c  = REG_W'(R_S1 + 1);
                src2_c  = REG_W'(R_F0 + 1);
                dest_c  = REG_W'(R_TMP);
                state_d = A2;
            end
            A2: begin
                op_c    = ODD_TAP_ACC;
                src1_c  = REG_W'(R_ACC);
                src2_c  = REG_W'(R_TMP);
                dest_c  = REG_W'(R_ACC);
                state_d = overflow ? ERR : M3;
            end
            M3: begin
                op_c    = MUL;
                src1_c  = REG_W'(R_S1 + 2);
                src2_c  = REG_W'(R_F0 + 2);
                dest_c  = REG_W'(R_TMP);
                state_d = A3;
            end
            A3: begin
                op_c    = ADD;
                src1_c  = REG_W'(R_ACC);
                src2_c  = REG_W'(R_TMP);
                dest_c  = REG_W'(R_ACC);
                state_d = overflow ? ERR : M4;
            end
            M4: begin
                op_c    = MUL;
                src1_c  = REG_W'(R_S1 + 3);
                src2_c  = REG_W'(R_F0 + 3);
                dest_c  = REG_W'(R_TMP);
                state_d = A4;
            end
            A4: begin
                op_c    = ODD_TAP_ACC;
                src1_c  = REG_W'(R_ACC);
                src2_c  = REG_W'(R_TMP);
                dest_c  = REG_W'(R_OUT);
                state_d = overflow ? ERR : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy/error flags are registered copies of where the FSM is heading.
        modwait_d = !(state_d inside {IDLE, ERR});
        err_d     = (state_d == ERR);
    end

    assign op      = OP_W'(op_c);
    assign src1    = src1_c;
    assign src2    = src2_c;
    assign dest    = dest_c;
    assign cnt_up  = cnt_up_c;
    assign clear   = clear_c;
    assign modwait = modwait_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fir_sequencer.sv
// Randomized scoreboard bench for fir_sequencer: expected command streams are
// built from the tap formula and checked by an independent monitor.
module tb_fir_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic       load_coeff;
    logic       overflow;
    logic [2:0] op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       cnt_up;
    logic       clear;
    logic       modwait;
    logic       err;

    int          vectors     = 0;
    int          miscompares = 0;
    int          coeff_model = 0;
    bit          mon_en      = 1'b0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    fir_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .load_coeff (load_coeff),
        .overflow   (overflow),
        .op         (op),
        .src1       (src1),
        .src2       (src2),
        .dest       (dest),
        .cnt_up     (cnt_up),
        .clear      (clear),
        .modwait    (modwait),
        .err        (err)
    );

    function automatic logic [16:0] cmd(input int o, input int s1, input int s2,
                                        input int d, input bit cu, input bit cl);
        return {3'(o), 4'(s1), 4'(s2), 4'(d), cu, cl};
    endfunction

    function automatic int acc_op(input int tap);
`ifdef FIR_SEQ_ALT_SIGN_EN
        return (tap % 2 == 1) ? 5 : 4;
`else
        return 4;
`endif
    endfunction

    // Reference: shift the delay line, load the sample, then y = sum(x[t]*F[t]).
    function automatic void push_sample(input int n);
        logic [16:0] seq[$];
        for (int k = 3; k >= 1; k--) seq.push_back(cmd(1, k, 0, k + 1, 1'b0, 1'b0));
        seq.push_back(cmd(2, 0, 0, 1, 1'b1, 1'b0));
        for (int t = 0; t < 4; t++) begin
            seq.push_back(cmd(6, 1 + t, 5 + t, (t == 0) ? 9 : 10, 1'b0, 1'b0));
            if (t > 0) seq.push_back(cmd(acc_op(t), 9, 10, (t == 3) ? 0 : 9, 1'b0, 1'b0));
        end
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    endfunction

    function automatic void push_coef();
        exp_q.push_back(cmd(3, 0, 0, 5 + coeff_model, 1'b0, coeff_model == 0));
        coeff_model = (coeff_model + 1) % 4;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (op != 3'd0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_cmd", {15'd0, op, src1, src2, dest, cnt_up, clear}, 32'd0);
                end else begin
                    check_output("cmd", {15'd0, op, src1, src2, dest, cnt_up, clear},
                                 {15'd0, exp_q.pop_front()});
                end
            end else begin
                check_output("nop_strobes", {30'd0, cnt_up, clear}, 32'd0);
            end
        end
    end

    task automatic apply_coef(input int hold);
        int idle_c;
        idle_c = (hold + 1 > 3) ? hold + 1 : 3;
        push_coef();
        @(posedge clk); #1;
        load_coeff = 1'b1;
        for (int c = 1; c <= idle_c; c++) begin
            @(posedge clk); #1;
            if (c == hold) load_coeff = 1'b0;
            @(negedge clk);
            check_output("coef_modwait", modwait, c < idle_c);
            check_output("coef_err", err, 1'b0);
        end
    endtask

    // kind 0: normal (overflow pulsed on non-accumulate cycle pidx),
    // kind 1: sample withdrawn early, kind 2: overflow on accumulate cycle pidx.
    task automatic apply_stimulus(input int kind, input int pidx);
        int last_busy;
        last_busy = (kind == 0) ? 10 : (kind == 1) ? 3 : pidx;
        push_sample((kind == 0) ? 11 : (kind == 1) ? 3 : pidx + 1);
        @(posedge clk); #1;
        data_ready = 1'b1;
        for (int i = 0; i <= last_busy + 1; i++) begin
            @(posedge clk); #1;
            if (kind == 1 && i == 0) data_ready = 1'b0;
            if (kind != 1 && i == 4) data_ready = 1'b0;
            overflow = (kind != 1 && i == pidx);
            @(negedge clk);
            check_output("sample_modwait", modwait, i <= last_busy);
            check_output("sample_err", err, (i > last_busy) && (kind != 0));
        end
        overflow = 1'b0;
    endtask

    task automatic apply_priority();
        push_coef();
        push_sample(11);
        @(posedge clk); #1;
        load_coeff = 1'b1;
        data_ready = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == 1) load_coeff = 1'b0;
            if (c == 8) data_ready = 1'b0;
            @(negedge clk);
            check_output("prio_modwait", modwait, (c != 3) && (c != 15));
        end
    endtask

    task automatic apply_mid_reset();
        push_sample(6);
        @(posedge clk); #1;
        data_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) data_ready = 1'b0;
            if (i == 5) rst = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_output("rst_op", op, 32'd0);
        check_output("rst_modwait", modwait, 1'b0);
        check_output("rst_err", err, 1'b0);
        check_output("rst_flush", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        coeff_model = 0;
    endtask

    initial begin
        int noise[8] = '{0, 1, 2, 3, 4, 5, 7, 9};
        int accs[3]  = '{6, 8, 10};
        int r;
        rst        = 1'b1;
        data_ready = 1'b0;
        load_coeff = 1'b0;
        overflow   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_op", op, 32'd0);
        check_output("reset_dest", dest, 32'd0);
        check_output("reset_modwait", modwait, 1'b0);
        check_output("reset_err", err, 1'b0);
        check_output("reset_strobes", {cnt_up, clear}, 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int k = 0; k < 5; k++) apply_coef(1 + k % 3);
        apply_stimulus(0, 5);
        apply_stimulus(1, 0);
        apply_stimulus(2, 8);
        apply_stimulus(0, 9);
        apply_priority();
        apply_mid_reset();
        apply_coef(1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      apply_coef($urandom_range(1, 3));
            else if (r < 60) apply_stimulus(0, noise[$urandom_range(0, 7)]);
            else if (r < 80) apply_stimulus(1, 0);
            else             apply_stimulus(2, accs[$urandom_range(0, 2)]);
        end
        apply_priority();

        repeat (2) @(posedge clk);
        check_output("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
